// File: rtl/arbitro16.sv
// arbitro16: 16-way round-robin arbiter with per-grant time limit and lock.
// Grants are registered, one at a time, with one idle cycle between grants.
module arbitro16 #(
    parameter int TEMPO_MAX = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Pedido,
    input  logic        Trava,
    output logic [3:0]  Escolha,
    output logic [15:0] Concessao,
    output logic        Valido
);

    localparam int         NUM_LANES = 16;
    localparam logic [7:0] TMAX      = 8'(TEMPO_MAX);

    typedef enum logic {OCIOSO, CONCEDIDO} estado_t;

    estado_t               estado, estado_n;
    logic [3:0]            ponteiro, ponteiro_n;
    logic [7:0]            contador, contador_n;
    logic [3:0]            escolha_n;
    logic [NUM_LANES-1:0]  concessao_n;
    logic                  valido_n;

    logic [2*NUM_LANES-1:0] dobrado;
    logic [NUM_LANES-1:0]   rodado;
    logic [3:0]             desloc;
    logic [3:0]             vencedor;
    logic                   limite;
    logic                   fim;

    // Rotate requests so that bit 0 corresponds to the round-robin start index.
    assign dobrado = {Pedido, Pedido} >> ponteiro;
    assign rodado  = dobrado[NUM_LANES-1:0];

    // Lowest set bit of the rotated vector = first requester at or after ponteiro.
    always_comb begin
        desloc = 4'd0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (rodado[i]) desloc = 4'(i);
        end
    end

    // 4-bit addition wraps 15 -> 0 naturally.
    assign vencedor = ponteiro + desloc;
    assign limite   = (contador >= TMAX);
    // Lock only suppresses the timeout; a dropped request always ends the grant.
    assign fim      = !Pedido[Escolha] || (limite && !Trava);

    // Next-state and next-output logic; everything holds unless changed below.
    always_comb begin
        estado_n    = estado;
        ponteiro_n  = ponteiro;
        contador_n  = contador;
        escolha_n   = Escolha;
        concessao_n = Concessao;
        valido_n    = Valido;
        case (estado)
            OCIOSO: begin
                valido_n    = 1'b0;
                concessao_n = '0;
                if (|Pedido) begin
                    estado_n    = CONCEDIDO;
                    escolha_n   = vencedor;
                    concessao_n = 16'(1) << vencedor;
                    valido_n    = 1'b1;
                    contador_n  = 8'd1;
                end
            end
            CONCEDIDO: begin
                if (fim) begin
                    estado_n    = OCIOSO;
                    valido_n    = 1'b0;
                    concessao_n = '0;
                    contador_n  = 8'd0;
                    ponteiro_n  = Escolha + 4'd1;
                end else if (!limite) begin
                    contador_n  = contador + 8'd1;
                end
            end
            default: begin
                estado_n    = OCIOSO;
                valido_n    = 1'b0;
                concessao_n = '0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset overrides all inputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado    <= OCIOSO;
            ponteiro  <= 4'd0;
            contador  <= 8'd0;
            Escolha   <= 4'd0;
            Concessao <= '0;
            Valido    <= 1'b0;
        end else begin
            estado    <= estado_n;
            ponteiro  <= ponteiro_n;
            contador  <= contador_n;
            Escolha   <= escolha_n;
            Concessao <= concessao_n;
            Valido    <= valido_n;
        end
    end

endmodule

// File: doc/arbitro16.md
ARBITRO16 -- requirements
Module: arbitro16

Interface
REQ-001 Parameter: TEMPO_MAX, default 8, maximum grant length in cycles (legal range 1..255).
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset; sampled on rising edge of Clock.
REQ-004 Pedido  input  16  request lines, bit i = requester i; level-sensitive.
REQ-005 Trava  input  1  lock; while 1, the current grant is not ended by timeout.
REQ-006 Escolha  output  4  index of the current/last granted requester; drives a 4-to-16 one-hot select decoder.
REQ-007 Concessao  output  16  one-hot grant; bit Escolha set only while Valido=1, else all zero.
REQ-008 Valido  output  1  1 while a grant is active.

Function
REQ-009 The block SHALL implement two states: OCIOSO (no grant) and CONCEDIDO (grant active); all outputs registered.
REQ-010 Internal registers SHALL be: state, Ponteiro (4 bits, round-robin start index), Contador (8 bits, saturating at TEMPO_MAX).
REQ-011 In OCIOSO with Pedido=0: stay in OCIOSO; Valido=0, Concessao=0, Escolha holds its last value.
REQ-012 In OCIOSO with Pedido!=0: at the next edge, select the first set bit searching Ponteiro, Ponteiro+1, ... mod 16 (15 wraps to 0); load Escolha with that index, Concessao with its one-hot, Valido=1, Contador=1, state CONCEDIDO.
REQ-013 Grant latency SHALL be exactly one cycle from the edge at which Pedido is sampled non-zero in OCIOSO.
REQ-014 In CONCEDIDO, Contador SHALL increment by 1 per cycle and saturate at TEMPO_MAX (no wrap).
REQ-015 In CONCEDIDO the grant SHALL end at the next edge when Pedido[Escolha]=0, or when Contador>=TEMPO_MAX and Trava=0.
REQ-016 On grant end: state OCIOSO, Valido=0, Concessao=0, Contador=0, Ponteiro=Escolha+1 mod 16; Escolha unchanged.
REQ-017 After any grant end, Valido SHALL be 0 for exactly one cycle before any new grant (no back-to-back grants).
REQ-018 Changes on Pedido bits other than Escolha during CONCEDIDO SHALL have no effect on the current grant.
REQ-019 Trava in OCIOSO SHALL have no effect; Trava never prevents release by Pedido[Escolha]=0.
REQ-020 With TEMPO_MAX=1 and Trava=0, each grant SHALL last exactly one cycle.
REQ-021 Concessao SHALL never have more than one bit set.

Reset
REQ-022 Reset=1 at an edge SHALL force state OCIOSO, Escolha=0, Concessao=0, Valido=0, Ponteiro=0, Contador=0, overriding every other input.
REQ-023 Reset asserted mid-grant SHALL drop the grant at that edge; first arbitration after Reset deasserts starts at index 0.
REQ-024 No output SHALL change asynchronously to Clock.

Verification
REQ-025 Reset, then Pedido=16'h0001 -> one edge later Valido=1, Escolha=0, Concessao=16'h0001.
REQ-026 TEMPO_MAX=8, Trava=0, Pedido=16'h8001 held -> grant 0 for 8 cycles, 1 idle, grant 15 for 8 cycles, 1 idle, grant 0 again (wrap).
REQ-027 Grant 3 active, Pedido changes to 16'h0010 after 2 cycles -> Valido=0 next cycle, Ponteiro=4, then Escolha=4, Concessao=16'h0010.
REQ-028 TEMPO_MAX=8, Trava=1, Pedido=16'h0020 held 20 cycles -> grant 5 held 20+ cycles, Contador=8; Trava drops -> Valido=0 at next edge.
REQ-029 Reset pulsed during grant 9 -> all outputs zero at that edge; Pedido=16'h0600 afterwards -> Escolha=9.
REQ-030 Pedido=0 for 50 cycles after reset -> Valido=0, Concessao=0, Escolha=0 throughout.
